note_timer: RTL and testbench
=============================

# note_timer

Sequential note-duration engine for the playback datapath. It accepts a 4-bit note length code, a dotted flag and the current cycles-per-beat tempo, and derives the note duration with a multi-cycle restoring divider instead of a wide combinational divide. It then times the note and drives a gate with a fixed articulation gap. It sits between the instruction decoder and the tone generator, with CNT_W generalising the duration width.

## Interface
- CNT_W, 64: width of tempo and duration values.
- GAP_SHIFT, 4: articulation gap = duration >> GAP_SHIFT.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  request to time a note.
- start_ready  out  1  high only in IDLE; a request is accepted when start_valid && start_ready.
- length  in  4  note length code; sampled on accept.
- dotted  in  1  1 = duration × 3/2; sampled on accept.
- cycles_per_beat  in  CNT_W  tempo; sampled on accept.
- stop  in  1  synchronous abort.
- gate  out  1  note sounding.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of the note.
- duration  out  CNT_W  last computed quotient Q; holds until the next quotient completes.

## Operation
- Divisor by length code 0..15: 1,2,3,4,5,6,7,8,9,10,12,15,16,24,32,64.
- Dividend, CNT_W+3 bits: cycles_per_beat×4, or ×6 when dotted. The dividend is exact, with no intermediate truncation.
- Quotient: floor(dividend/divisor). If it exceeds 2^CNT_W−1, Q saturates to all ones. Gap G = Q >> GAP_SHIFT.
- FSM states: IDLE, DIV, PLAY, FIN.
  - IDLE → DIV on accept. Inputs are latched here; later input changes are ignored.
  - DIV: one quotient bit per cycle for N = CNT_W+3 cycles. Then:
    - If Q = 0: → FIN.
    - Otherwise: → PLAY, with the counter loaded with Q.
  - PLAY: the counter decrements every cycle. gate = (counter > G). Move to FIN in the cycle the counter equals 1.
  - FIN: done = 1, gate = 0, then → IDLE.
- stop in DIV, PLAY or FIN: → IDLE next cycle. No done pulse, gate low next cycle, duration unchanged unless the division already completed.
- stop and start_valid together in IDLE: stop wins, and the request is not accepted.
- Reset values: state IDLE, gate 0, done 0, busy 0, start_ready 1, duration 0, and counter and divider registers 0.
- Reset mid-operation aborts immediately and asynchronously. No done pulse is emitted.

## Timing
- Accept at cycle T, which is the last IDLE cycle.
- DIV occupies T+1..T+N. duration updates at the edge ending T+N.
- Q > 0:
  - PLAY occupies T+N+1..T+N+Q.
  - gate is high in T+N+1..T+N+Q−G, i.e. Q−G cycles.
  - done is high in T+N+Q+1.
  - start_ready is high again from T+N+Q+2.
- Q = 0: done at T+N+1. gate never rises.
- Back-to-back notes: the minimum period is N+Q+2 cycles.
- gate, done, busy and start_ready are registered or pure state decodes. No combinational path from inputs to outputs.

## Structure
- Package note_pkg holds:
  - the state enum;
  - the 16-entry divisor constant array, 7-bit entries;
  - DOT_NUM=6 and PLAIN_NUM=4;
  - a function computing the dividend width from CNT_W.
- Sub-module seq_divider, parametrised by dividend width and 7-bit divisor:
  - start/busy/done handshake;
  - restoring algorithm, one bit per cycle;
  - saturation performed in note_timer.
- note_timer owns the FSM, the input latches, the duration counter and the gap compare.

## Test plan
All scenarios use CNT_W=16, GAP_SHIFT=4, so N=19.
- cps=100, length=3, dotted=0 → Q=100, G=6. gate high 94 cycles from T+20. done at T+120. start_ready at T+121.
- cps=1000, length=11 → Q=266 (4000/15), G=16. Same cps with length=7 and dotted=1 → Q=750 (6000/8).
- cps=0, any length → Q=0, gate never high, done at T+20. cps=0xFFFF, length=0, dotted=1 → Q saturates to 0xFFFF.
- stop asserted at cycle T+50 of the first case:
  - gate low from T+51, busy low from T+51;
  - no done;
  - duration=100;
  - a new request is accepted immediately.
- rst pulsed mid-DIV at T+5:
  - all outputs return to reset values asynchronously;
  - start_valid held high with changed inputs during DIV has no effect before the reset.
- Back-to-back requests with start_valid held high:
  - the second accept lands exactly at the start_ready cycle;
  - the length code sweeps 0..15 and every Q matches the divisor table.

Source files
------------

// File: rtl/note_pkg.sv
// Shared types and constants for the note duration engine.
// Holds FSM encoding, the length-code divisor table and dividend sizing.
package note_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_PLAY,
    ST_FIN
  } state_t;

  localparam logic [6:0] DIVISOR_TAB [16] = '{
    7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8,
    7'd9, 7'd10, 7'd12, 7'd15, 7'd16, 7'd24, 7'd32, 7'd64
  };

  localparam int DOT_NUM   = 6;
  localparam int PLAIN_NUM = 4;

  // cycles_per_beat x6 needs three extra bits to stay exact
  function automatic int dividend_width(input int cnt_w);
    return cnt_w + 3;
  endfunction

endpackage

// File: rtl/note_timer_if.sv
// Request/status bundle between the decoder, note_timer and the tone generator.
// start_valid/start_ready handshake; gate/done/busy/duration are status outputs.
interface note_timer_if #(parameter int CNT_W = 64);
  logic             start_valid;
  logic             start_ready;
  logic [3:0]       length;
  logic             dotted;
  logic [CNT_W-1:0] cycles_per_beat;
  logic             stop;
  logic             gate;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] duration;

  modport master (
    output start_valid, length, dotted, cycles_per_beat, stop,
    input  start_ready, gate, busy, done, duration
  );

  modport slave (
    input  start_valid, length, dotted, cycles_per_beat, stop,
    output start_ready, gate, busy, done, duration
  );
endinterface

// File: rtl/note_timer_seq_divider.sv
// Restoring divider, one quotient bit per cycle, DW cycles after start.
// done pulses during the final step with quotient already showing the result; abort wins over start.
module seq_divider #(
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dividend,
  input  logic [6:0]    divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);
  localparam int CW = $clog2(DW + 1);

  logic [6:0]    rem;
  logic [DW-1:0] quo;
  logic [CW-1:0] cnt;

  logic [7:0]    rem_sh;
  logic          ge;
  logic [6:0]    rem_nx;
  logic [DW-1:0] quo_nx;

  // quo starts as the dividend and fills with quotient bits from the LSB
  always_comb begin
    rem_sh = {rem, quo[DW-1]};
    ge     = rem_sh >= {1'b0, divisor};
    rem_nx = ge ? 7'(rem_sh - {1'b0, divisor}) : rem_sh[6:0];
    quo_nx = {quo[DW-2:0], ge};
  end

  assign busy     = (cnt != '0);
  assign done     = busy && (cnt == CW'(1));
  assign quotient = quo_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      cnt <= CW'(DW);
    end else if (busy) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/note_timer.sv
// Note duration engine: divides tempo by length code, then gates the note with an articulation gap.
// Latency CNT_W+3 divide cycles + Q play cycles + 1 done cycle; start_ready only in IDLE, stop aborts.
module note_timer
  import note_pkg::*;
#(
  parameter int CNT_W     = 64,
  parameter int GAP_SHIFT = 4
) (
  input logic         clk,
  input logic         rst,
  note_timer_if.slave bus
);
  localparam int DW = dividend_width(CNT_W);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] dur;
  logic [6:0]       divisor_lat;
  logic [DW-1:0]    dividend;
  logic [DW-1:0]    div_q;
  logic [CNT_W-1:0] q_sat;
  logic             div_busy, div_done, accept;

  assign accept = bus.start_valid && (state == ST_IDLE) && !bus.stop;

  always_comb begin
    dividend = bus.dotted ? DW'(bus.cycles_per_beat) * DW'(DOT_NUM)
                          : DW'(bus.cycles_per_beat) * DW'(PLAIN_NUM);
    q_sat    = (|div_q[DW-1:CNT_W]) ? '1 : div_q[CNT_W-1:0];
  end

  seq_divider #(.DW(DW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .abort    (bus.stop),
    .dividend (dividend),
    .divisor  (divisor_lat),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (accept) nxt = ST_DIV;
      ST_DIV:  if (div_done) nxt = (q_sat == '0) ? ST_FIN : ST_PLAY;
      ST_PLAY: if (cnt == CNT_W'(1)) nxt = ST_FIN;
      ST_FIN:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
    if (bus.stop) nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      gap         <= '0;
      dur         <= '0;
      divisor_lat <= '0;
    end else begin
      if (accept) divisor_lat <= DIVISOR_TAB[bus.length];
      if (bus.stop) begin
        cnt <= '0;
      end else if (state == ST_DIV && div_done) begin
        dur <= q_sat;
        gap <= q_sat >> GAP_SHIFT;
        cnt <= q_sat;
      end else if (state == ST_PLAY) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.gate        = (state == ST_PLAY) && (cnt > gap);
  assign bus.done        = (state == ST_FIN);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.start_ready = (state == ST_IDLE);
  assign bus.duration    = dur;

  // the divider is always mid-operation while the FSM sits in DIV
  div_busy_in_div: assert property (@(posedge clk) disable iff (rst)
                                    (state == ST_DIV) |-> div_busy);
endmodule

// File: tb/tb_note_timer.sv
// Scoreboard bench for note_timer: stimulus pushes model expectations, a monitor checks each done pulse.
module tb_note_timer;
  localparam int W  = 16;
  localparam int GS = 4;
  localparam int N  = W + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_timer_if #(.CNT_W(W)) bus ();
  note_timer #(.CNT_W(W), .GAP_SHIFT(GS)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    longint q;
    longint g;
    longint t;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  int unsigned div_tab [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 15, 16, 24, 32, 64};

  always @(posedge clk) cyc++;

  function automatic longint model_q(longint cps, int len, bit dot);
    longint d;
    d = (cps * (dot ? 6 : 4)) / div_tab[len];
    return (d > 65535) ? 65535 : d;
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: samples 1 time unit after each rising edge
  initial begin : monitor
    longint first_g = 0;
    int     gcnt    = 0;
    exp_t   e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        gcnt = 0;
        continue;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pending note (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("duration", bus.duration, e.q);
          chk("done_cycle", cyc, e.t + N + e.q + 1);
          chk("gate_cycles", gcnt, e.q - e.g);
          if (e.q > 0) chk("gate_rise", first_g, e.t + N + 1);
        end
      end
      if (!bus.busy) gcnt = 0;
      else if (bus.gate) begin
        if (gcnt == 0) first_g = cyc;
        gcnt++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // called on a falling edge; returns on the falling edge after the accept
  task automatic send(input longint cps, input int len, input bit dot,
                      input bit exp_done, input bit keep, output longint t);
    exp_t e;
    bus.start_valid     = 1'b1;
    bus.cycles_per_beat = W'(cps);
    bus.length          = 4'(len);
    bus.dotted          = dot;
    t = -1;
    for (int i = 0; i < 5000; i++) begin
      if (bus.start_ready && !bus.stop) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept required accept within 5000 cycles");
    end else if (exp_done) begin
      e.q = model_q(cps, len, dot);
      e.g = e.q >> GS;
      e.t = t;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!keep) bus.start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0 && !bus.busy) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy=%0b pending=%0d required idle", bus.busy, exp_q.size());
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin : stim
    longint t, t2, tprev, qprev;
    rst                 = 1'b1;
    bus.start_valid     = 1'b0;
    bus.length          = '0;
    bus.dotted          = 1'b0;
    bus.cycles_per_beat = '0;
    bus.stop            = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start_ready", bus.start_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gate", bus.gate, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_duration", bus.duration, 0);
    rst = 1'b0;
    @(negedge clk);

    send(100, 3, 0, 1, 0, t);
    wait_idle();
    chk("case1_q", bus.duration, 100);

    send(1000, 11, 0, 1, 0, t);
    wait_idle();
    chk("case2_q", bus.duration, 266);
    send(1000, 7, 1, 1, 0, t);
    wait_idle();
    chk("case3_q", bus.duration, 750);

    send(0, 5, 0, 1, 0, t);
    wait_idle();
    chk("zero_q", bus.duration, 0);

    // saturation: check the quotient, then abort the very long note
    send(16'hFFFF, 0, 1, 0, 0, t);
    wait_until(t + N + 1);
    chk("sat_q", bus.duration, 16'hFFFF);
    chk("sat_gate", bus.gate, 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("sat_stop_busy", bus.busy, 0);

    send(100, 3, 0, 0, 0, t);
    wait_until(t + 50);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_gate", bus.gate, 0);
    chk("stop_busy", bus.busy, 0);
    chk("stop_duration", bus.duration, 100);
    send(200, 4, 0, 1, 0, t2);
    chk("stop_reaccept", t2, t + 51);
    wait_idle();

    // reset mid-divide with a changed request held on the bus
    send(300, 2, 1, 0, 1, t);
    bus.cycles_per_beat = W'(5);
    bus.length          = 4'd0;
    bus.dotted          = 1'b0;
    while (cyc < t + 5) begin
      chk("div_ready_low", bus.start_ready, 0);
      chk("div_busy_high", bus.busy, 1);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.start_ready, 1);
    chk("arst_gate", bus.gate, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_duration", bus.duration, 0);
    bus.start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back sweep of every length code
    tprev = 0;
    qprev = 0;
    for (int len = 0; len < 16; len++) begin
      send(64, len, 0, 1, 1, t);
      if (len > 0) chk("b2b_accept", t, tprev + N + qprev + 2);
      tprev = t;
      qprev = model_q(64, len, 0);
    end
    bus.start_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      send($urandom_range(0, 150), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           1, 1'($urandom_range(0, 1)), t);
    end
    bus.start_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
